valu_wb_queue: RTL and testbench

//  Writeback queue directly downstream of the fixed-latency vALU lanes (merge, add, logic).

---
 rtl/valu_wb_queue_if.sv | 32 +++
 rtl/valu_wb_queue.sv | 142 ++++++++++++++
 tb/tb_valu_wb_queue.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/valu_wb_queue_if.sv
// Handshake bundle between the vALU lanes / issue logic and the writeback queue,
// plus the queue's drain port toward the vector register file.
interface valu_wb_queue_if #(
    parameter int RESP_DATA_WIDTH = 64,
    parameter int REQ_ADDR_WIDTH  = 32,
    parameter int DEPTH           = 8,
    parameter int CNT_WIDTH       = $clog2(DEPTH + 1)
);
    logic                       in_issue;
    logic                       in_valid;
    logic [REQ_ADDR_WIDTH-1:0]  in_addr;
    logic [RESP_DATA_WIDTH-1:0] in_vec;
    logic                       wr_ready;
    logic                       out_valid;
    logic [REQ_ADDR_WIDTH-1:0]  out_addr;
    logic [RESP_DATA_WIDTH-1:0] out_vec;
    logic                       out_issue_ok;
    logic [CNT_WIDTH-1:0]       out_count;
    logic                       out_err;

    // Driver side: issue logic, lanes and the VRF write port.
    modport master (
        output in_issue, in_valid, in_addr, in_vec, wr_ready,
        input  out_valid, out_addr, out_vec, out_issue_ok, out_count, out_err
    );

    // Queue side.
    modport slave (
        input  in_issue, in_valid, in_addr, in_vec, wr_ready,
        output out_valid, out_addr, out_vec, out_issue_ok, out_count, out_err
    );
endinterface

// File: rtl/valu_wb_queue.sv
// Writeback FIFO behind the vALU lanes with issue credit tracking.
// Optional macro VALU_WB_BYPASS_EN enables a zero-latency path when the FIFO is empty.
module valu_wb_queue #(
    parameter int RESP_DATA_WIDTH = 64,
    parameter int REQ_ADDR_WIDTH  = 32,
    parameter int DEPTH           = 8
) (
    input  logic              clk,
    input  logic              rst,
    valu_wb_queue_if.slave    bus
);
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

    typedef struct packed {
        logic [REQ_ADDR_WIDTH-1:0]  addr;
        logic [RESP_DATA_WIDTH-1:0] vec;
    } entry_t;

    entry_t               mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] inflight_q, inflight_d;
    logic                 err_q, err_d;

    logic                 empty;
    logic                 full;
    logic                 fifo_pop;
    logic                 push;
    logic                 overflow;
    logic                 underflow;
    logic                 bypass_take;
    logic [CNT_WIDTH:0]   reserved;
    entry_t               head;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    always_comb begin
        head = '0;
        if (!empty) begin
            head = mem_q[rd_ptr_q];
        end
    end

`ifdef VALU_WB_BYPASS_EN
    // An empty queue forwards the lane result directly; it is only stored if the VRF stalls.
    always_comb begin
        bus.out_valid = !empty;
        bus.out_addr  = head.addr;
        bus.out_vec   = head.vec;
        bypass_take   = 1'b0;
        if (empty && bus.in_valid) begin
            bus.out_valid = 1'b1;
            bus.out_addr  = bus.in_addr;
            bus.out_vec   = bus.in_vec;
            bypass_take   = bus.wr_ready;
        end
    end
`else
    always_comb begin
        bus.out_valid = !empty;
        bus.out_addr  = head.addr;
        bus.out_vec   = head.vec;
        bypass_take   = 1'b0;
    end
`endif

    // A pop frees a slot in the same cycle, so a full queue can still accept a push.
    assign fifo_pop = !empty && bus.wr_ready;
    assign push     = bus.in_valid && !bypass_take && (!full || fifo_pop);
    assign overflow = bus.in_valid && full && !fifo_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, fifo_pop})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
    end

    // In-flight ops saturate at DEPTH even if issue ignores the credit signal.
    always_comb begin
        inflight_d = inflight_q;
        underflow  = 1'b0;
        unique case ({bus.in_issue, bus.in_valid})
            2'b10: begin
                if (inflight_q != DEPTH_C) begin
                    inflight_d = inflight_q + CNT_WIDTH'(1);
                end
            end
            2'b01: begin
                if (inflight_q != '0) begin
                    inflight_d = inflight_q - CNT_WIDTH'(1);
                end else begin
                    underflow = 1'b1;
                end
            end
            default: inflight_d = inflight_q;
        endcase
        err_d = err_q || overflow || underflow;
    end

    assign reserved         = {1'b0, count_q} + {1'b0, inflight_q};
    assign bus.out_issue_ok = (reserved < {1'b0, DEPTH_C});
    assign bus.out_count    = count_q;
    assign bus.out_err      = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // Storage needs no reset: unread slots are masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{addr: bus.in_addr, vec: bus.in_vec};
        end
    end
endmodule

// File: tb/tb_valu_wb_queue.sv
// Scoreboard bench for valu_wb_queue: directed lane results are queued as expected
// VRF beats, and a monitor compares every accepted beat in order.
module tb_valu_wb_queue;
    localparam int DW    = 64;
    localparam int AW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    valu_wb_queue_if #(.RESP_DATA_WIDTH(DW), .REQ_ADDR_WIDTH(AW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) bus ();

    valu_wb_queue #(.RESP_DATA_WIDTH(DW), .REQ_ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] vec;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [DW-1:0] vecFor(input logic [AW-1:0] a);
        return {~a, a};
    endfunction

    task automatic drive(input logic issue, input logic valid, input logic [AW-1:0] addr,
                         input logic [DW-1:0] vec, input logic ready);
        bus.in_issue = issue;
        bus.in_valid = valid;
        bus.in_addr  = addr;
        bus.in_vec   = vec;
        bus.wr_ready = ready;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic issue, input logic valid, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] vec, input logic ready);
        drive(issue, valid, addr, vec, ready);
        step();
    endtask

    task automatic expectBeat(input logic [AW-1:0] addr, input logic [DW-1:0] vec);
        expQ.push_back('{addr: addr, vec: vec});
    endtask

    // Beats are accepted on the next rising edge; sample them mid-cycle.
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.wr_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_beat: got addr 0x%0h, expected no beat", bus.out_addr);
            end else begin
                monE = expQ.pop_front();
                checkOutput("beat_addr", 64'(bus.out_addr), 64'(monE.addr));
                checkOutput("beat_vec", bus.out_vec, monE.vec);
            end
        end
    end

    initial begin
        logic [3:0] expCount;
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset_addr", 64'(bus.out_addr), 64'd0);
        checkOutput("reset_vec", bus.out_vec, 64'd0);
        checkOutput("reset_count", 64'(bus.out_count), 64'd0);
        checkOutput("reset_err", 64'(bus.out_err), 64'd0);
        checkOutput("reset_issue_ok", 64'(bus.out_issue_ok), 64'd1);
        rst = 1'b1;
        step();

        // Single op through an empty queue.
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
        drive(1'b0, 1'b1, 32'h40, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1);
        expectBeat(32'h40, 64'hA5A5_A5A5_A5A5_A5A5);
        @(negedge clk);
`ifdef VALU_WB_BYPASS_EN
        checkOutput("single_same_cycle_valid", 64'(bus.out_valid), 64'd1);
        expCount = 4'd0;
`else
        checkOutput("single_latency_valid", 64'(bus.out_valid), 64'd0);
        expCount = 4'd1;
`endif
        step();
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        checkOutput("single_count", 64'(bus.out_count), 64'(expCount));
        checkOutput("single_valid_next", 64'(bus.out_valid), 64'(expCount));
        step();
        checkOutput("single_drain_count", 64'(bus.out_count), 64'd0);
        checkOutput("single_err", 64'(bus.out_err), 64'd0);

        // Fill under backpressure.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h100 + 32'(i), vecFor(32'h100 + 32'(i)), 1'b0);
            expectBeat(32'h100 + 32'(i), vecFor(32'h100 + 32'(i)));
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput("full_count", 64'(bus.out_count), 64'd8);
        checkOutput("full_issue_ok", 64'(bus.out_issue_ok), 64'd0);
        checkOutput("full_head_addr", 64'(bus.out_addr), 64'h100);
        checkOutput("full_err", 64'(bus.out_err), 64'd0);
        step();
        checkOutput("stall_head_addr", 64'(bus.out_addr), 64'h100);
        checkOutput("stall_head_vec", bus.out_vec, vecFor(32'h100));

        // Push and pop together while full.
        applyStimulus(1'b1, 1'b1, 32'h200, vecFor(32'h200), 1'b1);
        expectBeat(32'h200, vecFor(32'h200));
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput("pushpop_count", 64'(bus.out_count), 64'd8);
        checkOutput("pushpop_err", 64'(bus.out_err), 64'd0);
        checkOutput("pushpop_head_addr", 64'(bus.out_addr), 64'h101);

        // Overflow: the extra result is dropped.
        applyStimulus(1'b1, 1'b1, 32'hDEAD, vecFor(32'hDEAD), 1'b0);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput("overflow_count", 64'(bus.out_count), 64'd8);
        checkOutput("overflow_err", 64'(bus.out_err), 64'd1);
        checkOutput("overflow_head_addr", 64'(bus.out_addr), 64'h101);

        drive(1'b0, 1'b0, '0, '0, 1'b1);
        repeat (DEPTH) step();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput("drain_count", 64'(bus.out_count), 64'd0);
        checkOutput("drain_err_sticky", 64'(bus.out_err), 64'd1);
        checkOutput("drain_issue_ok", 64'(bus.out_issue_ok), 64'd1);

        // Reset in the middle of traffic discards everything.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h400 + 32'(i), vecFor(32'h400 + 32'(i)), 1'b0);
        end
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        checkOutput("midreset_pre_count", 64'(bus.out_count), 64'd3);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midreset_count", 64'(bus.out_count), 64'd0);
        checkOutput("midreset_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("midreset_addr", 64'(bus.out_addr), 64'd0);
        checkOutput("midreset_vec", bus.out_vec, 64'd0);
        checkOutput("midreset_err", 64'(bus.out_err), 64'd0);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        step();
        rst = 1'b1;
        step();
        checkOutput("postreset_issue_ok", 64'(bus.out_issue_ok), 64'd1);

        // Result with no outstanding credit flags an error but is still written back.
        applyStimulus(1'b0, 1'b1, 32'h500, vecFor(32'h500), 1'b0);
        expectBeat(32'h500, vecFor(32'h500));
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        checkOutput("underflow_err", 64'(bus.out_err), 64'd1);
        checkOutput("underflow_count", 64'(bus.out_count), 64'd1);
        step();
        checkOutput("underflow_drain_count", 64'(bus.out_count), 64'd0);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();

        // Credit exhaustion and saturation of the in-flight counter.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
            if (i == 3) checkOutput("credit_half_issue_ok", 64'(bus.out_issue_ok), 64'd1);
        end
        checkOutput("credit_exhausted_issue_ok", 64'(bus.out_issue_ok), 64'd0);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h300 + 32'(i), vecFor(32'h300 + 32'(i)), 1'b1);
            expectBeat(32'h300 + 32'(i), vecFor(32'h300 + 32'(i)));
        end
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        checkOutput("credit_return_count", 64'(bus.out_count), 64'd0);
        checkOutput("credit_return_err", 64'(bus.out_err), 64'd0);
        checkOutput("credit_return_issue_ok", 64'(bus.out_issue_ok), 64'd1);
        applyStimulus(1'b0, 1'b1, 32'h3FF, vecFor(32'h3FF), 1'b1);
        expectBeat(32'h3FF, vecFor(32'h3FF));
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        checkOutput("saturation_err", 64'(bus.out_err), 64'd1);
        step();

`ifdef VALU_WB_BYPASS_EN
        drive(1'b1, 1'b1, 32'h80, vecFor(32'h80), 1'b1);
        expectBeat(32'h80, vecFor(32'h80));
        @(negedge clk);
        checkOutput("bypass_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("bypass_addr", 64'(bus.out_addr), 64'h80);
        step();
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        checkOutput("bypass_count", 64'(bus.out_count), 64'd0);
`endif

        drive(1'b0, 1'b0, '0, '0, 1'b1);
        repeat (3) step();
        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
